// File: rtl/mlaccel_top.sv
// -----------------------------------------------------------------------------
// mlaccel_top
//   QPI-attached byte buffer accelerator. The host talks to a 256x8 buffer over
//   a DDR nibble bus (one nibble per qpi_clk edge, falling edge = high nibble).
//   Commands: 0x21 WRITE from addr 0, 0x22 READ from addr 0 (one dummy cycle),
//   0x23 COPY src,len,dst and 0x24 ADD src,len,dst (one dummy cycle, then status
//   bytes: 0x01 busy / 0x00 done). COPY/ADD run one byte per clock, ascending.
//
// Ports
//   clock          system clock, all state on rising edge
//   resetn         asynchronous active-low reset
//   qpi_csb        host chip-select, active-low (one low period = one transaction)
//   qpi_clk        host QPI clock, asynchronous, idles high
//   qpi_io0..3     bidirectional nibble bus, io3 = MSB; driven only when reading
//   qpi_rdy        high when no COPY/ADD operation is running
//   qpi_err        sticky protocol error flag
// -----------------------------------------------------------------------------
module mlaccel_top (
    input  logic clock,
    input  logic resetn,
    input  logic qpi_csb,
    input  logic qpi_clk,
    inout  wire  qpi_io0,
    inout  wire  qpi_io1,
    inout  wire  qpi_io2,
    inout  wire  qpi_io3,
    output logic qpi_rdy,
    output logic qpi_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ARGS, S_DATA_IN, S_DUMMY, S_DATA_OUT, S_ERR
    } state_t;

    state_t     state, state_n;

    logic [1:0] csb_sync, clk_sync;
    logic [3:0] io_meta, io_s;
    logic       clk_d;
    logic       csb_s, clk_s, clk_fall, clk_rise;
    logic       armed;

    logic       have_hi;
    logic [3:0] hi_nib;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic [1:0] arg_cnt;

    logic       err, op_busy, op_add, status_mode;
    logic [7:0] op_src, op_dst, op_cnt, op_wdata;
    logic [7:0] wr_addr, rd_addr, tx_byte, out_byte;
    logic [3:0] io_out;
    logic       io_oe;

    logic       err_set, err_clr, op_launch, wr_en;

    logic [7:0] mem [0:255];

    // Synchronizers. csb resets to "low" so that a transaction already in
    // flight at reset release is not mistaken for a fresh one; a real high
    // must be seen before anything is accepted (see armed).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_sync <= 2'b00;
            clk_sync <= 2'b11;
            clk_d    <= 1'b1;
            io_meta  <= 4'd0;
            io_s     <= 4'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            csb_sync <= {csb_sync[0], qpi_csb};
            clk_sync <= {clk_sync[0], qpi_clk};
            clk_d    <= clk_sync[1];
            io_meta  <= {qpi_io3, qpi_io2, qpi_io1, qpi_io0};
            io_s     <= io_meta;
        end
    end

    assign csb_s    = csb_sync[1];
    assign clk_s    = clk_sync[1];
    assign clk_fall = clk_d & ~clk_s;
    assign clk_rise = ~clk_d & clk_s;

    // io is synchronized alongside qpi_clk, so io_s in the edge cycle is the
    // nibble the host presented around that edge.
    assign rx_byte    = {hi_nib, io_s};
    assign byte_valid = clk_rise & have_hi & ~csb_s & (state != S_IDLE);

    assign out_byte = status_mode ? {7'd0, op_busy} : mem[rd_addr];
    assign op_wdata = op_add ? (mem[op_dst] + mem[op_src]) : mem[op_src];

    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        state_n   = state;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        op_launch = 1'b0;
        wr_en     = 1'b0;
        if (csb_s) begin
            state_n = S_IDLE;
            err_set = (state == S_ARGS);     // argument list cut short
        end else begin
            case (state)
                S_IDLE: if (armed) state_n = S_CMD;
                S_CMD: if (byte_valid) begin
                    case (rx_byte)
                        8'h21: if (op_busy) begin
                            err_set = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            err_clr = 1'b1;
                            state_n = S_DATA_IN;
                        end
                        8'h22: begin
                            err_clr = 1'b1;
                            state_n = S_DUMMY;
                        end
                        8'h23, 8'h24: if (op_busy) begin
                            err_set = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            err_clr = 1'b1;
                            state_n = S_ARGS;
                        end
                        default: begin
                            err_set = 1'b1;
                            state_n = S_ERR;
                        end
                    endcase
                end
                S_ARGS: if (byte_valid && arg_cnt == 2'd2) begin
                    state_n   = S_DUMMY;
                    op_launch = (op_cnt != 8'd0);   // len was the 2nd argument
                end
                S_DATA_IN: wr_en = byte_valid;
                // Command's last edge was a rise, so the next rise closes the
                // dummy fall+rise pair.
                S_DUMMY: if (clk_rise) state_n = S_DATA_OUT;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            armed       <= 1'b0;
            err         <= 1'b0;
            have_hi     <= 1'b0;
            hi_nib      <= 4'd0;
            arg_cnt     <= 2'd0;
            status_mode <= 1'b0;
            op_busy     <= 1'b0;
            op_add      <= 1'b0;
            op_src      <= 8'd0;
            op_dst      <= 8'd0;
            op_cnt      <= 8'd0;
            wr_addr     <= 8'd0;
            rd_addr     <= 8'd0;
            tx_byte     <= 8'd0;
            io_out      <= 4'd0;
            io_oe       <= 1'b0;
        end else begin
            state <= state_n;
            if (csb_s) armed <= 1'b1;

            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            // Nibble assembly; a partial byte is dropped when csb rises.
            if (csb_s || state == S_IDLE) begin
                have_hi <= 1'b0;
            end else if (clk_fall) begin
                have_hi <= 1'b1;
                hi_nib  <= io_s;
            end else if (clk_rise) begin
                have_hi <= 1'b0;
            end

            if (state == S_CMD && byte_valid) begin
                arg_cnt     <= 2'd0;
                wr_addr     <= 8'd0;
                rd_addr     <= 8'd0;
                status_mode <= (rx_byte != 8'h22);
                if (state_n == S_ARGS) op_add <= (rx_byte == 8'h24);
            end

            // Arguments load straight into the engine registers; ARGS is only
            // reachable while the engine is idle.
            if (state == S_ARGS && byte_valid) begin
                case (arg_cnt)
                    2'd0:    op_src <= rx_byte;
                    2'd1:    op_cnt <= rx_byte;
                    default: op_dst <= rx_byte;
                endcase
                arg_cnt <= arg_cnt + 2'd1;
            end

            if (state == S_DATA_IN && byte_valid) wr_addr <= wr_addr + 8'd1;

            if (op_launch) begin
                op_busy <= 1'b1;
            end else if (op_busy) begin
                op_src <= op_src + 8'd1;
                op_dst <= op_dst + 8'd1;
                op_cnt <= op_cnt - 8'd1;
                if (op_cnt == 8'd1) op_busy <= 1'b0;
            end

            // Read phase: the falling edge fetches the whole byte, so the low
            // nibble is ready the moment the rising edge arrives.
            if (state == S_DATA_OUT && !csb_s) begin
                if (clk_fall) begin
                    tx_byte <= out_byte;
                    io_out  <= out_byte[7:4];
                    io_oe   <= 1'b1;
                end else if (clk_rise) begin
                    io_out <= tx_byte[3:0];
                    if (!status_mode) rd_addr <= rd_addr + 8'd1;
                end
            end
            if (csb_s) io_oe <= 1'b0;
        end
    end

    // NOTE: the buffer has no reset; its contents survive resetn by design,
    // and leaving it out of the reset keeps it mappable to RAM.
    always_ff @(posedge clock) begin
        if (op_busy)    mem[op_dst]  <= op_wdata;
        else if (wr_en) mem[wr_addr] <= rx_byte;
    end

    assign qpi_io0 = io_oe ? io_out[0] : 1'bz;
    assign qpi_io1 = io_oe ? io_out[1] : 1'bz;
    assign qpi_io2 = io_oe ? io_out[2] : 1'bz;
    assign qpi_io3 = io_oe ? io_out[3] : 1'bz;

    assign qpi_rdy = ~op_busy;
    assign qpi_err = err;

endmodule

// File: tb/tb_mlaccel_top.sv
// -----------------------------------------------------------------------------
// tb_mlaccel_top
//   Directed bench for mlaccel_top: reset state, write/read, copy, add with
//   wrap, overlap copy, len=0, protocol errors, busy rejection, reset during an
//   operation and write address wrap. QPI phases are 4 system clocks long.
// -----------------------------------------------------------------------------
module tb_mlaccel_top;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       qpi_csb = 1'b1;
    logic       qpi_clk = 1'b1;
    logic       tb_oe   = 1'b0;
    logic [3:0] tb_dat  = 4'd0;
    wire        qpi_io0, qpi_io1, qpi_io2, qpi_io3;
    logic       qpi_rdy, qpi_err;
    wire  [3:0] io_bus;

    int total = 0;
    int bad   = 0;
    int busy_clks = 0;

    assign qpi_io0 = tb_oe ? tb_dat[0] : 1'bz;
    assign qpi_io1 = tb_oe ? tb_dat[1] : 1'bz;
    assign qpi_io2 = tb_oe ? tb_dat[2] : 1'bz;
    assign qpi_io3 = tb_oe ? tb_dat[3] : 1'bz;
    assign io_bus  = {qpi_io3, qpi_io2, qpi_io1, qpi_io0};

    mlaccel_top dut (
        .clock   (clock),
        .resetn  (resetn),
        .qpi_csb (qpi_csb),
        .qpi_clk (qpi_clk),
        .qpi_io0 (qpi_io0),
        .qpi_io1 (qpi_io1),
        .qpi_io2 (qpi_io2),
        .qpi_io3 (qpi_io3),
        .qpi_rdy (qpi_rdy),
        .qpi_err (qpi_err)
    );

    always #5 clock = ~clock;

    // Clocks with an operation running (qpi_rdy low).
    always @(negedge clock) if (resetn && !qpi_rdy) busy_clks++;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic start_txn();
        qpi_csb = 1'b0;
        #30;
    endtask

    task automatic stop_txn();
        tb_oe   = 1'b0;
        qpi_csb = 1'b1;
        #60;
    endtask

    task automatic byte_out(input logic [7:0] b);
        tb_oe  = 1'b1;
        tb_dat = b[7:4];
        #20 qpi_clk = 1'b0;
        #20 tb_dat = b[3:0];
        #20 qpi_clk = 1'b1;
        #20;
    endtask

    task automatic byte_in(output logic [7:0] b);
        tb_oe = 1'b0;
        #20 qpi_clk = 1'b0;
        #38 b[7:4] = io_bus;
        #2  qpi_clk = 1'b1;
        #38 b[3:0] = io_bus;
        #2;
    endtask

    task automatic dummy_cycle();
        tb_oe = 1'b0;
        #20 qpi_clk = 1'b0;
        #40 qpi_clk = 1'b1;
        #20;
    endtask

    task automatic check_hiz(input string tag);
        check(tag, {28'd0, io_bus}, {28'd0, 4'bzzzz});
    endtask

    // Reads n (<= 8) bytes from address 0; exp lists them left to right.
    task automatic read_check(input string tag, input int n, input logic [63:0] exp);
        logic [7:0] b;
        start_txn();
        byte_out(8'h22);
        dummy_cycle();
        for (int i = 0; i < n; i++) begin
            byte_in(b);
            check($sformatf("%s[%0d]", tag, i), {24'd0, b}, {24'd0, exp[(n-1-i)*8 +: 8]});
        end
        stop_txn();
        check_hiz({tag, "_hiz"});
    endtask

    task automatic run_op(input logic [7:0] cmd, input logic [7:0] src, input logic [7:0] len,
                          input logic [7:0] dst, output bit done);
        logic [7:0] s;
        start_txn();
        byte_out(cmd);
        byte_out(src);
        byte_out(len);
        byte_out(dst);
        dummy_cycle();
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            byte_in(s);
            if (s == 8'h00) done = 1'b1;
        end
        stop_txn();
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 2000 && !qpi_rdy; i++) @(posedge clock);
        #1 check(tag, {31'd0, qpi_rdy}, 32'd1);
    endtask

    initial begin
        bit         done;
        int         b0;
        logic [7:0] st;

        // Reset state
        #1;
        check("rst_rdy", {31'd0, qpi_rdy}, 32'd1);
        check("rst_err", {31'd0, qpi_err}, 32'd0);
        check_hiz("rst_hiz");
        #30 resetn = 1'b1;
        #50;

        // Write 01..0C, read back 8
        start_txn();
        byte_out(8'h21);
        for (int i = 1; i <= 12; i++) byte_out(8'(i));
        stop_txn();
        read_check("rd_wr", 8, 64'h0102030405060708);

        // Copy 08,04,00 -> exactly 4 busy clocks
        b0 = busy_clks;
        run_op(8'h23, 8'h08, 8'h04, 8'h00, done);
        check("cp_done", {31'd0, done}, 32'd1);
        check("cp_busy_clks", busy_clks - b0, 32'd4);
        check("cp_rdy", {31'd0, qpi_rdy}, 32'd1);
        check("cp_err", {31'd0, qpi_err}, 32'd0);
        read_check("rd_cp", 8, 64'h090A0B0C05060708);

        // Add 00,02,04
        b0 = busy_clks;
        run_op(8'h24, 8'h00, 8'h02, 8'h04, done);
        check("add_done", {31'd0, done}, 32'd1);
        check("add_busy_clks", busy_clks - b0, 32'd2);
        read_check("rd_add", 8, 64'h090A0B0C0E100708);

        // Add overflow: F0 + 20 = 0x10
        start_txn();
        byte_out(8'h21);
        byte_out(8'hF0);
        byte_out(8'h20);
        stop_txn();
        run_op(8'h24, 8'h01, 8'h01, 8'h00, done);
        check("ovf_done", {31'd0, done}, 32'd1);
        read_check("rd_ovf", 2, 64'h1020);

        // Overlapping ascending copy propagates buf[0]
        run_op(8'h23, 8'h00, 8'h03, 8'h01, done);
        read_check("rd_ovl", 4, 64'h10101010);

        // len = 0 is a no-op
        b0 = busy_clks;
        run_op(8'h23, 8'h00, 8'h00, 8'h05, done);
        check("len0_busy_clks", busy_clks - b0, 32'd0);
        check("len0_err", {31'd0, qpi_err}, 32'd0);
        read_check("rd_len0", 6, 64'h101010100E10);

        // Invalid command: sticky error, rest of transaction ignored
        start_txn();
        byte_out(8'h30);
        byte_out(8'h21);
        byte_out(8'h77);
        stop_txn();
        check("bad_cmd_err", {31'd0, qpi_err}, 32'd1);
        read_check("rd_bad_cmd", 2, 64'h1010);
        check("bad_cmd_clr", {31'd0, qpi_err}, 32'd0);

        // Early csb during arguments: error, nothing starts
        b0 = busy_clks;
        start_txn();
        byte_out(8'h24);
        byte_out(8'h05);
        byte_out(8'h01);
        stop_txn();
        check("early_err", {31'd0, qpi_err}, 32'd1);
        check("early_busy_clks", busy_clks - b0, 32'd0);
        read_check("rd_early", 6, 64'h101010100E10);

        // Busy rejection of WRITE
        b0 = busy_clks;
        start_txn();
        byte_out(8'h23);
        byte_out(8'h00);
        byte_out(8'hFF);
        byte_out(8'h00);
        dummy_cycle();
        byte_in(st);
        check("busy_status", {24'd0, st}, 32'h01);
        stop_txn();
        start_txn();
        byte_out(8'h21);
        byte_out(8'hAA);
        byte_out(8'hBB);
        stop_txn();
        check("busy_err", {31'd0, qpi_err}, 32'd1);
        check("busy_rdy_low", {31'd0, qpi_rdy}, 32'd0);
        wait_rdy("busy_wait_rdy");
        check("busy_busy_clks", busy_clks - b0, 32'd255);
        read_check("rd_busy", 2, 64'h1010);

        // Reset during a running copy
        start_txn();
        byte_out(8'h23);
        byte_out(8'h00);
        byte_out(8'hFF);
        byte_out(8'h00);
        dummy_cycle();
        byte_in(st);
        check("mid_status", {24'd0, st}, 32'h01);
        resetn = 1'b0;
        #1;
        check("mid_rst_rdy", {31'd0, qpi_rdy}, 32'd1);
        check("mid_rst_err", {31'd0, qpi_err}, 32'd0);
        check_hiz("mid_rst_hiz");
        #20 resetn = 1'b1;
        #30;
        byte_out(8'h30);                  // csb never went high: must be ignored
        #20;
        check("post_rst_ignored", {31'd0, qpi_err}, 32'd0);
        check("post_rst_rdy", {31'd0, qpi_rdy}, 32'd1);
        stop_txn();
        read_check("rd_post_rst", 2, 64'h1010);

        // Write address wraps modulo 256
        start_txn();
        byte_out(8'h21);
        for (int i = 0; i < 258; i++) byte_out((i < 256) ? 8'hAA : 8'h55);
        stop_txn();
        read_check("rd_wrap", 3, 64'h5555AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlaccel_top.md
MLACCEL_TOP -- requirements
Module: mlaccel_top

Interface
REQ-001 clock  input  1  system clock; every register in the block is clocked on its rising edge.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 qpi_csb  input  1  host chip-select, active-low; a low period is one transaction.
REQ-004 qpi_clk  input  1  host QPI clock, asynchronous to clock; idles high.
REQ-005 qpi_io0..qpi_io3  inout  1 each  nibble bus, io3 = MSB; block drives it only during the read phase.
REQ-006 qpi_rdy  output  1  high = no buffer operation running.
REQ-007 qpi_err  output  1  high = protocol error latched.

Function
REQ-008 The block SHALL synchronize qpi_csb, qpi_clk and qpi_io through 2-flop synchronizers and detect qpi_clk edges in the clock domain.
REQ-009 The host drives qpi_clk high/low phases of at least 1.5 clock periods each.
REQ-010 Transfer is DDR, one nibble per qpi_clk edge, starting with the first falling edge after qpi_csb falls: falling edge = bits[7:4], rising edge = bits[3:0].
REQ-011 The block SHALL sample the nibble present after each detected edge.
REQ-012 Byte 0 is the command; later bytes are arguments or data.
REQ-013 The block SHALL have a 256x8 internal buffer; all addresses wrap modulo 256.
REQ-014 0x21 WRITE: each following byte SHALL be written to the buffer starting at address 0 and auto-incrementing; the write ends on qpi_csb high.
REQ-015 0x22 READ: one dummy qpi_clk cycle (falling + rising edge, host tri-stated) follows the command; then the block SHALL return buffer bytes from address 0, auto-incrementing, for as long as qpi_csb stays low.
REQ-016 0x23 COPY src,len,dst: after the 3rd argument the block SHALL execute buf[dst+i] = buf[src+i] for i = 0..len-1 in ascending order, one byte per clock.
REQ-017 For COPY, overlapping regions propagate (ascending order); len = 0 is a no-op.
REQ-018 0x24 ADD src,len,dst: the block SHALL execute buf[dst+i] = (buf[dst+i] + buf[src+i]) mod 256, ascending, one byte per clock.
REQ-019 For 0x23/0x24, one dummy cycle follows the 3rd argument; every status byte read afterwards SHALL be 0x01 while the operation runs and 0x00 once it is complete.
REQ-020 The host polls status until it reads 0x00.
REQ-021 Read phase: the block SHALL drive each nibble within 3 clock cycles of the edge that starts it, prefetching the next byte so that no gaps occur.
REQ-022 The block SHALL release io to hi-Z within 3 clock cycles of qpi_csb rising.
REQ-023 qpi_rdy SHALL drop in the clock after an operation is launched and SHALL rise in the clock after its last byte is written.
REQ-024 The operation SHALL continue to completion if qpi_csb rises early.
REQ-025 qpi_err SHALL be set by any of:
- a command byte not in {0x21..0x24};
- 0x21/0x23/0x24 received while qpi_rdy = 0 (that command is ignored);
- qpi_csb rising before all 3 arguments of 0x23/0x24 are received (the operation does not start).
REQ-026 qpi_err SHALL be sticky and SHALL be cleared when the next valid command byte is accepted.
REQ-027 After an invalid command, the block SHALL ignore the rest of the transaction.
REQ-028 qpi_csb rising at any point SHALL return the QPI state machine to IDLE and discard any partial byte.
REQ-029 QPI FSM states and transitions:
- IDLE -> CMD on qpi_csb low;
- CMD -> ARGS (0x23/0x24) or DATA_IN (0x21) or DUMMY (0x22) or ERR;
- ARGS -> DUMMY after 3 bytes;
- DUMMY -> DATA_OUT after 2 edges;
- all states -> IDLE on qpi_csb high.

Reset
REQ-030 While resetn = 0 the block SHALL hold qpi_rdy = 1, qpi_err = 0, io hi-Z, FSM = IDLE, with any running operation aborted.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 Reset asserted mid-transaction or mid-operation SHALL take effect immediately; after release the block SHALL wait for qpi_csb high before accepting a new command.

Verification
REQ-033 Reset: assert resetn = 0 -> qpi_rdy = 1, qpi_err = 0, io hi-Z.
REQ-034 Write/read: 0x21 01..0C, then 0x22 + dummy + 8 reads -> 01 02 03 04 05 06 07 08.
REQ-035 Copy: after REQ-034, 0x23 08 04 00 -> status polls 0x01... then 0x00 with qpi_rdy low then high; 0x22 -> 09 0A 0B 0C 05 06 07 08.
REQ-036 Add with wrap: after REQ-035, 0x24 00 02 04 -> 0x22 returns 09 0A 0B 0C 0E 10 07 08.
REQ-037 Add overflow: buf[0] = 0xF0, buf[1] = 0x20 via 0x21, then 0x24 01 01 00 -> buf[0] = 0x10.
REQ-038 Errors: command 0x30 -> qpi_err = 1; a following 0x22 clears it.
REQ-039 Busy error: 0x23 00 FF 00 followed immediately by 0x21 -> qpi_err = 1 and the buffer is unchanged by the 0x21.
REQ-040 Reset mid-copy: resetn = 0 during 0x23 -> qpi_rdy = 1 immediately.
